// File: rtl/uc_rr_scheduler.sv
// Round-robin drain of per-engine unit-clause queues into the arbiter's single PQ-mode input.
// Handles pop sequencing, downstream backpressure, halt on conflict and round quiescence.
module uc_rr_scheduler #(
  parameter int unsigned NUM_ENGINE   = 4,
  parameter int unsigned LIT_W        = 8,
  parameter int unsigned QUIET_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ENGINE-1:0]           eng_empty,
  input  logic [NUM_ENGINE*LIT_W-1:0]     eng_uc,
  output logic [NUM_ENGINE-1:0]           eng_pop,
  input  logic                            out_ready,
  input  logic                            conflict,
  output logic                            out_valid,
  output logic [LIT_W-1:0]                out_uc,
  output logic [$clog2(NUM_ENGINE)-1:0]   grant_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            halted,
  output logic [CNT_W-1:0]                fwd_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_ENGINE);
  localparam int unsigned QW    = $clog2(QUIET_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENGINE - 1);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_q;
  logic [QW-1:0]    quiet_q;
  logic             out_valid_q;
  logic [LIT_W-1:0] out_uc_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [CNT_W-1:0] fwd_cnt_q;
  logic             done_q;

  logic             slot_free;
  logic             can_pop;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [LIT_W-1:0] pick_uc;
  logic             transfer;
  logic             idle_cyc;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  assign slot_free = !out_valid_q || out_ready;
  assign transfer  = out_valid_q && out_ready;
  assign idle_cyc  = (&eng_empty) && !out_valid_q;
  // Conflict and reset both veto the pop so no clause is lost from an engine queue.
  assign can_pop   = (state_q == StRun) && !conflict && !rst && slot_free && pick_valid;

  // First non-empty queue at or after the rr pointer, with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_uc    = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_ENGINE) begin
        cand = cand - NUM_ENGINE;
      end
      cand_idx = IDX_W'(cand);
      if (!pick_valid && !eng_empty[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_uc = eng_uc[i*LIT_W +: LIT_W];
      end
    end
  end

  always_comb begin
    eng_pop = '0;
    for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
      eng_pop[i] = can_pop && (IDX_W'(i) == pick_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      quiet_q     <= '0;
      out_valid_q <= 1'b0;
      out_uc_q    <= '0;
      grant_idx_q <= '0;
      fwd_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (conflict) begin
            state_q     <= StHalt;
            out_valid_q <= 1'b0;
          end else if (start) begin
            state_q   <= StRun;
            fwd_cnt_q <= '0;
            quiet_q   <= '0;
          end
        end
        StRun: begin
          if (conflict) begin
            state_q     <= StHalt;
            out_valid_q <= 1'b0;
            out_uc_q    <= '0;
          end else begin
            if (transfer && !(&fwd_cnt_q)) begin
              fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
            if (can_pop) begin
              out_valid_q <= 1'b1;
              out_uc_q    <= pick_uc;
              grant_idx_q <= pick_idx;
              rr_q        <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end else if (transfer) begin
              out_valid_q <= 1'b0;
            end
            if (idle_cyc) begin
              if (quiet_q == QUIET_LAST) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                quiet_q <= '0;
              end else begin
                quiet_q <= quiet_q + 1'b1;
              end
            end else begin
              quiet_q <= '0;
            end
          end
        end
        StHalt: begin
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_uc    = out_uc_q;
  assign grant_idx = grant_idx_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign done      = done_q;
  assign busy      = (state_q == StRun);
  assign halted    = (state_q == StHalt);

endmodule

// File: doc/uc_rr_scheduler.md
Name: uc_rr_scheduler

Overview:
- Round-robin scheduler that drains implied unit clauses from the NUM_ENGINE per-engine output queues.
- Presents the drained clauses one at a time to the unit-clause arbiter's single PQ-mode input (eng2uca_valid/eng2uca).
- Owns queue pop sequencing, downstream backpressure, halt on conflict, and quiescence (BCP round done) detection.
- Sits between the engine array and the unit-clause arbiter; the arbiter operates with input_mode=1 while this block is active.

Parameters:
NUM_ENGINE, 4, number of engine queues served (>=2).
LIT_W, 8, signed literal width ($clog2(`LIT_IDX_MAX)+1).
QUIET_CYCLES, 4, consecutive idle cycles before round declared done (>=1).
CNT_W, 16, width of forwarded-clause counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begin a scheduling round.
eng_empty  in  NUM_ENGINE  per-engine queue empty flag.
eng_uc  in  NUM_ENGINE*LIT_W  per-engine head literal, first-word-fallthrough, valid when !eng_empty[i].
eng_pop  out  NUM_ENGINE  one-hot pop to the granted engine queue.
out_ready  in  1  downstream can accept (arbiter queue not full).
conflict  in  1  arbiter conflict flag; level.
out_valid  out  1  out_uc holds a clause.
out_uc  out  LIT_W  forwarded literal.
grant_idx  out  $clog2(NUM_ENGINE)  index of last granted engine.
busy  out  1  FSM in RUN.
done  out  1  one-cycle pulse at round quiescence.
halted  out  1  FSM in HALT.
fwd_cnt  out  CNT_W  clauses accepted downstream this round, saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, rr pointer 0, all outputs 0, output register empty.
- States:
  - IDLE: no pops. start -> RUN; fwd_cnt cleared, quiet counter cleared, rr pointer kept.
  - RUN: scheduling active; busy=1.
  - HALT: entered from RUN or IDLE whenever conflict=1. No pops; out_valid forced 0 and the pending clause is discarded; halted=1. Only rst exits.
- conflict has priority over start and all RUN actions in the same cycle.
- Grant rule (RUN only), with slot_free = !out_valid | out_ready:
  - When slot_free, pick the first i with !eng_empty[i], searching from rr pointer upward with wrap.
  - Assert eng_pop[i] combinationally in that cycle.
  - Next cycle: out_uc = sampled eng_uc[i], out_valid=1, grant_idx=i, rr pointer = (i+1) mod NUM_ENGINE.
- Throughput and latency:
  - Latency from pop to out_valid is 1 cycle.
  - Peak throughput is one clause per cycle while out_ready=1.
- Backpressure:
  - out_valid/out_uc are held stable while out_ready=0.
  - No pop occurs in a cycle with out_valid=1 and out_ready=0.
- Transfer:
  - A transfer is out_valid & out_ready.
  - On transfer, fwd_cnt += 1, saturating at all-ones.
- Quiescence:
  - Idle cycle in RUN = all eng_empty=1 and out_valid=0.
  - The quiet counter increments on an idle cycle and clears on any other cycle.
  - When the counter reaches QUIET_CYCLES, done pulses for 1 cycle and the FSM goes RUN -> IDLE.
- eng_pop is never asserted for an engine whose eng_empty=1, nor outside RUN.
- start while already in RUN is ignored.
- fwd_cnt holds its value in IDLE until the next start.
- Literal passes through unmodified (sign = polarity); no width arithmetic is applied.
- Reset mid-round: all state returns to reset values the next cycle, and the pending clause is dropped.

Test Plan:
1. Reset, start, all queues empty -> no eng_pop; done pulses exactly QUIET_CYCLES cycles after entering RUN; busy then 0; fwd_cnt=0.
2. NUM_ENGINE=4, queues 0..3 each hold one literal (+3,-5,+7,-9), out_ready=1 -> pops in order 0,1,2,3 on consecutive cycles; out_uc sequence +3,-5,+7,-9; fwd_cnt=4; done follows.
3. Engines 1 and 3 always non-empty, rr pointer=2 -> grant order 3,1,3,1; no starvation.
4. out_valid=1 with out_uc=-5 and out_ready=0 for 5 cycles -> out_uc stable, eng_pop=0 throughout; on out_ready=1 transfer occurs and the next pop happens in the same cycle.
5. conflict=1 mid-stream with clause pending -> next cycle halted=1, out_valid=0, eng_pop=0; start ignored until rst; after rst all outputs are 0.
6. Preload fwd_cnt with CNT_W=4 via 17 transfers -> fwd_cnt saturates at 15; rst asserted in RUN -> state IDLE, rr pointer 0.
